lcd_responder: RTL and testbench
================================

LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 Parameter BUSY_CYCLES, default 50: clk cycles busy asserts after any accepted write other than clear.
REQ-002 Parameter CLEAR_CYCLES, default 2000: clk cycles busy asserts after an accepted clear-display command; SHALL be at least 32.
REQ-003 clk  in  1  system clock; the single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 lcd_rs  in  1  register select: 0 instruction/status, 1 data.
REQ-006 lcd_rw  in  1  0 write, 1 read.
REQ-007 lcd_e  in  1  bus enable strobe.
REQ-008 lcd_data_in  in  8  bus data driven by the initiator.
REQ-009 lcd_data_out  out  8  read-back data toward the initiator.
REQ-010 lcd_data_oe  out  1  high while lcd_e=1 and lcd_rw=1 (registered, 1-cycle lag).
REQ-011 rd_index  in  5  local character-buffer read index: 0-15 line 1, 16-31 line 2.
REQ-012 rd_char  out  8  buffer[rd_index], registered, 1-cycle latency.
REQ-013 cursor  out  5  current buffer address.
REQ-014 display_on  out  1  display-control D bit.
REQ-015 busy  out  1  busy flag.
REQ-016 cmd_valid  out  1  one-cycle pulse per accepted instruction write; cmd_code out 8 holds its byte.
REQ-017 err  out  1  sticky flag: write/data-read while busy, or illegal DDRAM address.

Function
REQ-018 Bus transaction SHALL be captured on the lcd_e falling edge (e_d=1, e=0, e_d registered); rs, rw, data sampled in that cycle.
REQ-019 rs=0 rw=0, not busy: decode by highest set bit: 0x01 clear; 0x02-0x03 home (cursor=0); 0x04-0x07 entry mode, ID=bit1; 0x08-0x0F display_on=bit2; 0x10-0x1F with bit3=0 moves cursor (bit2=1 right, 0 left), bit3=1 ignored; 0x20-0x7F accepted, no state change; 0x80-0xFF set DDRAM address.
REQ-020 DDRAM address 0x00-0x0F maps to cursor 0-15, 0x40-0x4F to 16-31; any other address sets err, cursor unchanged, still starts busy.
REQ-021 Clear SHALL write 0x20 into one buffer entry per cycle, entries 0..31, set cursor=0, ID=1, busy for CLEAR_CYCLES.
REQ-022 rs=1 rw=0, not busy: buffer[cursor]<=data, then cursor+1 (ID=1) or -1 (ID=0), wrapping 31->0 and 0->31.
REQ-023 rs=0 rw=1: lcd_data_out={busy, DDRAM address of cursor (0x00-0x0F or 0x40-0x4F)}; always allowed; no state change.
REQ-024 rs=1 rw=1: lcd_data_out=buffer[cursor] while e high; at falling edge cursor advances per ID; if busy, returns 0x00, sets err, cursor unchanged.
REQ-025 Any write while busy SHALL be dropped and set err; busy counter not restarted.
REQ-026 Busy rises the cycle after the accepting falling edge, falls exactly N cycles later (N=BUSY_CYCLES or CLEAR_CYCLES).
REQ-027 rd_char SHALL be read-before-write: a same-cycle write to rd_index shows the old value, new value one cycle later.
REQ-028 err clears only on rst.

Reset
REQ-029 rst SHALL set all 32 entries to 0x20, cursor=0, ID=1, display_on=0, busy=0, err=0, cmd_valid=0, cmd_code=0x00, lcd_data_out=0x00, lcd_data_oe=0, rd_char=0x20, e_d=0.
REQ-030 rst mid-clear or mid-busy SHALL abort and take REQ-029 values the next cycle.

Structure
REQ-031 Shared package lcd_pkg SHALL hold command masks, BLANK=0x20, LINE1_BASE=0x00, LINE2_BASE=0x40, DEPTH=32.
REQ-032 Sub-module lcd_cmd_decode (combinational) SHALL map an instruction byte to a command class and its fields.

Verification
REQ-033 After rst, write 0x80, then data 0x41,0x42 with waits >50 cycles -> buffer[0]=0x41, buffer[1]=0x42, cursor=2, rd_char(rd_index=1)=0x42.
REQ-034 Write 0xCF then data 0x5A -> buffer[31]=0x5A, cursor wraps to 0; status read returns 0x00 after busy ends.
REQ-035 Write 0x01, status read at +10 cycles -> 0x80; at +2001 cycles -> 0x00; all entries 0x20.
REQ-036 Data write 20 cycles after a prior write -> dropped, err=1, buffer unchanged.
REQ-037 Entry mode 0x04, DDRAM 0x80, data 0x33 -> buffer[0]=0x33, cursor=31.
REQ-038 Assert rst at clear +5 cycles -> next cycle busy=0, cursor=0, entries 0x20, err=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, command classes and address helpers for the HD44780-style responder.
package lcd_pkg;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    localparam logic [7:0] BLANK      = 8'h20;
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;

    localparam logic [7:0] MASK_CLEAR   = 8'h01;
    localparam logic [7:0] MASK_HOME    = 8'h02;
    localparam logic [7:0] MASK_ENTRY   = 8'h04;
    localparam logic [7:0] MASK_DISPLAY = 8'h08;
    localparam logic [7:0] MASK_SHIFT   = 8'h10;
    localparam logic [7:0] MASK_FUNC    = 8'h20;
    localparam logic [7:0] MASK_CGRAM   = 8'h40;
    localparam logic [7:0] MASK_DDRAM   = 8'h80;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISPLAY,
        CMD_SHIFT,
        CMD_DDRAM
    } cmd_kind_t;

    typedef struct packed {
        cmd_kind_t       kind;
        logic            inc;
        logic            disp_on;
        logic            move;
        logic            right;
        logic            addr_ok;
        logic [AW-1:0]   addr_cursor;
    } cmd_t;

    // Buffer index 0-15 is line 1, 16-31 is line 2.
    function automatic logic [6:0] cursor_to_ddram(input logic [AW-1:0] c);
        return (c[4] ? LINE2_BASE : LINE1_BASE) | {3'b000, c[3:0]};
    endfunction

endpackage

// File: rtl/lcd_cmd_decode.sv
// Combinational instruction decoder: classifies a byte by its highest set bit.
module lcd_cmd_decode
    import lcd_pkg::*;
(
    input  logic [7:0] code,
    output cmd_t       cmd
);

    always_comb begin
        cmd             = '0;
        cmd.kind        = CMD_NOP;
        cmd.inc         = code[1];
        cmd.disp_on     = code[2];
        cmd.right       = code[2];
        cmd.addr_ok     = (code[6:4] == 3'b000) || (code[6:4] == 3'b100);
        cmd.addr_cursor = {code[6], code[3:0]};

        if ((code & MASK_DDRAM) != 8'h00) begin
            cmd.kind = CMD_DDRAM;
        end else if ((code & (MASK_CGRAM | MASK_FUNC)) != 8'h00) begin
            cmd.kind = CMD_NOP;
        end else if ((code & MASK_SHIFT) != 8'h00) begin
            cmd.kind = CMD_SHIFT;
            cmd.move = ~code[3];
        end else if ((code & MASK_DISPLAY) != 8'h00) begin
            cmd.kind = CMD_DISPLAY;
        end else if ((code & MASK_ENTRY) != 8'h00) begin
            cmd.kind = CMD_ENTRY;
        end else if ((code & MASK_HOME) != 8'h00) begin
            cmd.kind = CMD_HOME;
        end else if ((code & MASK_CLEAR) != 8'h00) begin
            cmd.kind = CMD_CLEAR;
        end
    end

endmodule

// File: rtl/lcd_responder.sv
// Character-LCD bus responder: 32-entry DDRAM buffer, busy timing, status/data read-back.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 50,
    parameter int unsigned CLEAR_CYCLES = 2000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lcd_rs,
    input  logic          lcd_rw,
    input  logic          lcd_e,
    input  logic [7:0]    lcd_data_in,
    output logic [7:0]    lcd_data_out,
    output logic          lcd_data_oe,
    input  logic [AW-1:0] rd_index,
    output logic [7:0]    rd_char,
    output logic [AW-1:0] cursor,
    output logic          display_on,
    output logic          busy,
    output logic          cmd_valid,
    output logic [7:0]    cmd_code,
    output logic          err
);

    localparam int unsigned MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [7:0]       mem [DEPTH];
    logic             e_d;
    logic             id;
    logic             clearing;
    logic [AW-1:0]    clr_idx;
    logic [CNT_W-1:0] busy_cnt;
    logic             fall;
    logic [AW-1:0]    cursor_step;
    cmd_t             cmd;

    lcd_cmd_decode u_decode (
        .code (lcd_data_in),
        .cmd  (cmd)
    );

    assign fall        = e_d & ~lcd_e;
    assign cursor_step = id ? (cursor + 5'd1) : (cursor - 5'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= BLANK;
            cursor       <= '0;
            id           <= 1'b1;
            display_on   <= 1'b0;
            busy         <= 1'b0;
            busy_cnt     <= '0;
            err          <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_code     <= 8'h00;
            lcd_data_out <= 8'h00;
            lcd_data_oe  <= 1'b0;
            rd_char      <= BLANK;
            e_d          <= 1'b0;
            clearing     <= 1'b0;
            clr_idx      <= '0;
        end else begin
            e_d         <= lcd_e;
            lcd_data_oe <= lcd_e & lcd_rw;
            cmd_valid   <= 1'b0;
            rd_char     <= mem[rd_index];

            // busy_cnt holds the number of further cycles busy stays high
            if (busy) begin
                if (busy_cnt == '0) busy <= 1'b0;
                else                busy_cnt <= busy_cnt - 1'b1;
            end

            if (clearing) begin
                mem[clr_idx] <= BLANK;
                clr_idx      <= clr_idx + 5'd1;
                if (clr_idx == AW'(DEPTH - 1)) clearing <= 1'b0;
            end

            if (lcd_e && lcd_rw) begin
                lcd_data_out <= lcd_rs ? (busy ? 8'h00 : mem[cursor])
                                       : {busy, cursor_to_ddram(cursor)};
            end

            if (fall) begin
                if (!lcd_rw) begin
                    if (busy) begin
                        err <= 1'b1;
                    end else begin
                        busy     <= 1'b1;
                        busy_cnt <= CNT_W'(BUSY_CYCLES - 1);
                        if (lcd_rs) begin
                            mem[cursor] <= lcd_data_in;
                            cursor      <= cursor_step;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= lcd_data_in;
                            case (cmd.kind)
                                CMD_CLEAR: begin
                                    busy_cnt <= CNT_W'(CLEAR_CYCLES - 1);
                                    clearing <= 1'b1;
                                    clr_idx  <= '0;
                                    cursor   <= '0;
                                    id       <= 1'b1;
                                end
                                CMD_HOME:    cursor     <= '0;
                                CMD_ENTRY:   id         <= cmd.inc;
                                CMD_DISPLAY: display_on <= cmd.disp_on;
                                CMD_SHIFT: begin
                                    if (cmd.move) cursor <= cmd.right ? (cursor + 5'd1) : (cursor - 5'd1);
                                end
                                CMD_DDRAM: begin
                                    if (cmd.addr_ok) cursor <= cmd.addr_cursor;
                                    else             err    <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end else if (lcd_rs) begin
                    if (busy) err    <= 1'b1;
                    else      cursor <= cursor_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: cycle model of the bus rules plus directed literal checks.
module tb_lcd_responder;

    localparam int unsigned BUSY_N  = 50;
    localparam int unsigned CLEAR_N = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [4:0] rd_index = 5'd0;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       display_on;
    logic       busy;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       err;

    int total = 0;
    int bad   = 0;

    lcd_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .lcd_data_in  (lcd_data_in),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .rd_index     (rd_index),
        .rd_char      (rd_char),
        .cursor       (cursor),
        .display_on   (display_on),
        .busy         (busy),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ddaddr(input int c);
        return (c < 16) ? c : c + 48;
    endfunction

    // Behavioural model: buffer array, integer cursor, busy as remaining-cycle count.
    int   m_buf [32];
    int   m_cur, m_id, m_disp, m_err, m_busy_left, m_clr, m_e_prev, busy_now, d, a;
    int   exp_out, exp_oe, exp_rd, exp_cv, exp_code;
    logic m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_buf[i] = 32;
            m_cur = 0; m_id = 1; m_disp = 0; m_err = 0; m_busy_left = 0; m_clr = 32; m_e_prev = 0;
            exp_out = 0; exp_oe = 0; exp_rd = 32; exp_cv = 0; exp_code = 0;
            m_valid = 1'b1;
        end else begin
            busy_now = (m_busy_left > 0) ? 1 : 0;
            if (m_busy_left > 0) m_busy_left--;
            exp_rd = m_buf[rd_index];
            exp_oe = (lcd_e && lcd_rw) ? 1 : 0;
            exp_cv = 0;
            if (lcd_e && lcd_rw)
                exp_out = lcd_rs ? (busy_now ? 0 : m_buf[m_cur]) : busy_now * 128 + ddaddr(m_cur);
            if (m_clr < 32) begin
                m_buf[m_clr] = 32;
                m_clr++;
            end
            if (m_e_prev == 1 && !lcd_e) begin
                d = int'(lcd_data_in);
                if (!lcd_rw) begin
                    if (busy_now == 1) m_err = 1;
                    else begin
                        m_busy_left = BUSY_N;
                        if (lcd_rs) begin
                            m_buf[m_cur] = d;
                            m_cur = (m_cur + (m_id == 1 ? 1 : 31)) % 32;
                        end else begin
                            exp_cv = 1;
                            exp_code = d;
                            if (d >= 128) begin
                                a = d - 128;
                                if (a < 16) m_cur = a;
                                else if (a >= 64 && a < 80) m_cur = a - 48;
                                else m_err = 1;
                            end else if (d >= 32) begin
                                m_cur = m_cur;
                            end else if (d >= 16) begin
                                if ((d / 8) % 2 == 0) m_cur = (m_cur + ((d / 4) % 2 == 1 ? 1 : 31)) % 32;
                            end else if (d >= 8) m_disp = (d / 4) % 2;
                            else if (d >= 4) m_id = (d / 2) % 2;
                            else if (d >= 2) m_cur = 0;
                            else if (d == 1) begin
                                m_busy_left = CLEAR_N;
                                m_clr = 0;
                                m_cur = 0;
                                m_id = 1;
                            end
                        end
                    end
                end else if (lcd_rs) begin
                    if (busy_now == 1) m_err = 1;
                    else m_cur = (m_cur + (m_id == 1 ? 1 : 31)) % 32;
                end
            end
            m_e_prev = lcd_e ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("data_out",   lcd_data_out, exp_out);
            check("data_oe",    lcd_data_oe,  exp_oe);
            check("rd_char",    rd_char,      exp_rd);
            check("cursor",     cursor,       m_cur);
            check("display_on", display_on,   m_disp);
            check("busy",       busy,         (m_busy_left > 0) ? 1 : 0);
            check("cmd_valid",  cmd_valid,    exp_cv);
            check("cmd_code",   cmd_code,     exp_code);
            check("err",        err,          m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic rs, input logic [7:0] v);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = v; lcd_e = 1'b1;
        tick(2);
        lcd_e = 1'b0;
        tick(1);
    endtask

    task automatic rd(input logic rs, output logic [7:0] v);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        tick(2);
        v = lcd_data_out;
        lcd_e = 1'b0;
        tick(1);
        lcd_rw = 1'b0;
    endtask

    task automatic peek(input int idx, output logic [7:0] v);
        rd_index = 5'(idx);
        tick(2);
        v = rd_char;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int         blanks;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_cursor", cursor, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_char", rd_char, 8'h20);
        check("rst_err", err, 0);

        wr(0, 8'h80); tick(60);
        wr(1, 8'h41); tick(60);
        wr(1, 8'h42); tick(60);
        peek(1, v); check("buf1_42", v, 8'h42);
        peek(0, v); check("buf0_41", v, 8'h41);
        check("cursor_2", cursor, 2);

        wr(0, 8'hCF); tick(60);
        wr(1, 8'h5A); tick(60);
        peek(31, v); check("buf31_5a", v, 8'h5A);
        check("cursor_wrap0", cursor, 0);
        rd(0, v); check("status_idle", v, 8'h00);

        wr(1, 8'h77); tick(20);
        wr(1, 8'h99);
        check("err_drop", err, 1);
        tick(60);
        peek(0, v); check("buf0_77", v, 8'h77);
        peek(1, v); check("buf1_kept", v, 8'h42);
        check("cursor_drop", cursor, 1);

        wr(0, 8'h01); tick(7);
        rd(0, v); check("status_clear_busy", v, 8'h80);
        tick(2001);
        rd(0, v); check("status_clear_done", v, 8'h00);
        blanks = 0;
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            if (v == 8'h20) blanks++;
        end
        check("clear_all_blank", blanks, 32);

        wr(0, 8'h04); tick(60);
        wr(0, 8'h80); tick(60);
        wr(1, 8'h33); tick(60);
        peek(0, v); check("buf0_33", v, 8'h33);
        check("cursor_dec31", cursor, 31);

        wr(0, 8'h01); tick(5);
        rst = 1'b1;
        tick(1);
        check("midclr_busy", busy, 0);
        check("midclr_cursor", cursor, 0);
        check("midclr_err", err, 0);
        rst = 1'b0;
        tick(1);
        blanks = 0;
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            if (v == 8'h20) blanks++;
        end
        check("midclr_blank", blanks, 32);

        wr(0, 8'h0C); tick(60);
        check("display_on", display_on, 1);
        wr(0, 8'h90); tick(2);
        check("bad_addr_err", err, 1);
        check("bad_addr_cursor", cursor, 0);
        check("bad_addr_busy", busy, 1);
        tick(60);
        wr(1, 8'h55); tick(60);
        wr(0, 8'h14); tick(60);
        check("shift_right", cursor, 2);
        wr(0, 8'h10); tick(60);
        check("shift_left", cursor, 1);
        wr(0, 8'h18); tick(60);
        check("shift_ignored", cursor, 1);
        wr(0, 8'h80); tick(60);
        rd(1, v); check("data_read", v, 8'h55);
        check("data_read_adv", cursor, 1);
        wr(0, 8'hC5);
        rd(0, v); check("status_busy_line2", v, 8'hC5);
        tick(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
